ir_queue: RTL

//  Parametrised instruction-register queue for the LC-3b datapath: buffers up to DEPTH fetched

---
 rtl/lc3b_types.sv | 32 +++
 rtl/ir_field_decode.sv | 47 ++++
 rtl/ir_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b datapath types: instruction word, opcode,
//               register index, offsets, trap vector and 4-bit immediate.
// Revision    : 1.0 - initial release with ir_queue support types
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [4:0]  lc3b_offset5;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;
  typedef logic [7:0]  lc3b_trapvect8;
  typedef logic [3:0]  lc3b_imm4;

  // Word presented downstream when no instruction is available.
  localparam lc3b_word c_NULL_WORD = 16'h0000;

  // Forces an instruction word to the null word when it is not valid, so a
  // stale entry can never leak into decode as a real instruction.
  function automatic lc3b_word lc3b_gate_word(input logic valid, input lc3b_word word);
    return valid ? word : c_NULL_WORD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_field_decode.sv
// ============================================================================
// Module      : ir_field_decode
// Description : Combinational split of an LC-3b instruction word into its
//               standard fields. Reusable by any decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_field_decode
  import lc3b_types::*;
(
  input  lc3b_word      instr,
  output lc3b_opcode    opcode,
  output lc3b_reg       dest,
  output lc3b_reg       src1,
  output lc3b_reg       src2,
  output lc3b_offset5   offset5,
  output lc3b_offset6   offset6,
  output lc3b_offset9   offset9,
  output lc3b_offset11  offset11,
  output logic          imm_mode,
  output logic          a,
  output logic          d,
  output logic          jsr_mode,
  output lc3b_imm4      imm4,
  output lc3b_trapvect8 trap_vector
);

  // Fields overlap freely; each consumer picks the one its opcode needs.
  assign opcode      = instr[15:12];
  assign dest        = instr[11:9];
  assign src1        = instr[8:6];
  assign src2        = instr[2:0];
  assign offset5     = instr[4:0];
  assign offset6     = instr[5:0];
  assign offset9     = instr[8:0];
  assign offset11    = instr[10:0];
  assign imm_mode    = instr[5];
  assign a           = instr[5];
  assign d           = instr[4];
  assign jsr_mode    = instr[11];
  assign imm4        = instr[3:0];
  assign trap_vector = instr[7:0];

endmodule

`default_nettype wire

// File: rtl/ir_queue.sv
// ============================================================================
// Module      : ir_queue
// Description : DEPTH-entry instruction-register FIFO between fetch and
//               decode. Holds each fetched word with its PC and presents the
//               head entry split into LC-3b fields. Optional same-cycle
//               fetch-to-decode bypass when IR_QUEUE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  lc3b_word                     in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output lc3b_opcode                   opcode,
  output lc3b_reg                      dest,
  output lc3b_reg                      src1,
  output lc3b_reg                      src2,
  output lc3b_offset5                  offset5,
  output lc3b_offset6                  offset6,
  output lc3b_offset9                  offset9,
  output lc3b_offset11                 offset11,
  output logic                         imm_mode,
  output logic                         a,
  output logic                         d,
  output logic                         jsr_mode,
  output lc3b_imm4                     imm4,
  output lc3b_trapvect8                trap_vector,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  lc3b_word          r_word_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_bypass;
  logic              w_write;
  logic              w_read;
  lc3b_word          w_head_word;
  logic [PC_W-1:0]   w_head_pc;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

`ifdef IR_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming word straight to decode.
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens a slot for a push; this keeps in_ready free of out_ready.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty || w_bypass;

  // A bypassed word consumed in the same cycle never occupies a slot.
  assign w_write = in_valid && !w_full && !(w_bypass && out_ready);
  assign w_read  = out_valid && out_ready && !w_empty;

  // Head entry: bypass path, stored head, or the null word when empty.
  always_comb begin
    w_head_word = lc3b_gate_word(!w_empty, r_word_mem[r_rd_ptr]);
    w_head_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    if (w_bypass) begin
      w_head_word = in_instr;
      w_head_pc   = in_pc;
    end
  end

  assign out_pc = w_head_pc;
  assign count  = r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_write && !flush) begin
      r_word_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]   <= in_pc;
    end
  end

  // Pointer and occupancy update; flush overrides any push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_read)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_read);
    end
  end

  ir_field_decode u_field_decode (
    .instr       (w_head_word),
    .opcode      (opcode),
    .dest        (dest),
    .src1        (src1),
    .src2        (src2),
    .offset5     (offset5),
    .offset6     (offset6),
    .offset9     (offset9),
    .offset11    (offset11),
    .imm_mode    (imm_mode),
    .a           (a),
    .d           (d),
    .jsr_mode    (jsr_mode),
    .imm4        (imm4),
    .trap_vector (trap_vector)
  );

endmodule

`default_nettype wire
